// File: rtl/dispatch_hs.sv
// dispatch_hs: registered ID->EXE dispatch stage.
// Takes a DECODE_WIDTH-wide bundle from ID under a valid/accept handshake.
// Operands come from the regfile (read in the same cycle) or from the
// forwarding ports. A bundle is split when a younger slot reads a register
// that an older accepted slot in the same bundle writes. The six
// branch-compare flags are precomputed from the forwarded source operands.
//
// Handshake: a slot moves from ID into the output register when it is
// accepted. EXE takes every valid output slot together on exe_ready_i.
// While exe_valid_o is nonzero and exe_ready_i is low, all outputs hold
// and nothing is accepted.
//
// Optional build macro DISPATCH_PERF_CNT_EN adds the stall and split
// counters perf_stall_cnt_o / perf_split_cnt_o.
module dispatch_hs #(
    parameter int DECODE_WIDTH   = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FWD_PORTS      = 2,
    parameter int PAYLOAD_WIDTH  = 64
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     flush_i,
    input  logic [DECODE_WIDTH-1:0]                  id_valid_i,
    output logic [DECODE_WIDTH-1:0]                  id_accept_o,
    input  logic [DECODE_WIDTH*2-1:0]                id_reg_read_valid_i,
    input  logic [DECODE_WIDTH*2*REG_ADDR_WIDTH-1:0] id_reg_read_addr_i,
    input  logic [DECODE_WIDTH-1:0]                  id_use_imm_i,
    input  logic [DECODE_WIDTH*DATA_WIDTH-1:0]       id_imm_i,
    input  logic [DECODE_WIDTH-1:0]                  id_reg_write_valid_i,
    input  logic [DECODE_WIDTH*REG_ADDR_WIDTH-1:0]   id_reg_write_addr_i,
    input  logic [DECODE_WIDTH*PAYLOAD_WIDTH-1:0]    id_payload_i,
    output logic [DECODE_WIDTH*2-1:0]                regfile_reg_read_valid_o,
    output logic [DECODE_WIDTH*2*REG_ADDR_WIDTH-1:0] regfile_reg_read_addr_o,
    input  logic [DECODE_WIDTH*2*DATA_WIDTH-1:0]     regfile_reg_read_data_i,
    input  logic [FWD_PORTS-1:0]                     fwd_valid_i,
    input  logic [FWD_PORTS*REG_ADDR_WIDTH-1:0]      fwd_addr_i,
    input  logic [FWD_PORTS*DATA_WIDTH-1:0]          fwd_data_i,
    input  logic                                     exe_ready_i,
    output logic [DECODE_WIDTH-1:0]                  exe_valid_o,
    output logic [DECODE_WIDTH*DATA_WIDTH-1:0]       exe_oprand1_o,
    output logic [DECODE_WIDTH*DATA_WIDTH-1:0]       exe_oprand2_o,
    output logic [DECODE_WIDTH*DATA_WIDTH-1:0]       exe_imm_o,
    output logic [DECODE_WIDTH*6-1:0]                exe_branch_com_result_o,
    output logic [DECODE_WIDTH-1:0]                  exe_reg_write_valid_o,
    output logic [DECODE_WIDTH*REG_ADDR_WIDTH-1:0]   exe_reg_write_addr_o,
`ifdef DISPATCH_PERF_CNT_EN
    output logic [31:0]                              perf_stall_cnt_o,
    output logic [31:0]                              perf_split_cnt_o,
`endif
    output logic [DECODE_WIDTH*PAYLOAD_WIDTH-1:0]    exe_payload_o
);

    localparam int NSRC = DECODE_WIDTH * 2;
    localparam int RA   = REG_ADDR_WIDTH;
    localparam int DW   = DATA_WIDTH;

    logic [DECODE_WIDTH-1:0]              r_exe_valid;
    logic [DECODE_WIDTH*DW-1:0]           r_oprand1;
    logic [DECODE_WIDTH*DW-1:0]           r_oprand2;
    logic [DECODE_WIDTH*DW-1:0]           r_imm;
    logic [DECODE_WIDTH*6-1:0]            r_flags;
    logic [DECODE_WIDTH-1:0]              r_wr_valid;
    logic [DECODE_WIDTH*RA-1:0]           r_wr_addr;
    logic [DECODE_WIDTH*PAYLOAD_WIDTH-1:0] r_payload;

    logic                    w_advance;
    logic [DECODE_WIDTH-1:0] w_accepted;
    logic [DECODE_WIDTH-1:0] w_hazard;
    logic [DECODE_WIDTH-1:0] w_prior_ok;
    logic                    w_lower_ok;
    logic                    w_split;
    logic [DW-1:0]           w_src [NSRC];
    logic [DECODE_WIDTH*DW-1:0] w_op2;
    logic [DECODE_WIDTH*6-1:0]  w_flags;

    assign w_advance                = ~|r_exe_valid | exe_ready_i;
    assign id_accept_o              = w_accepted;
    assign regfile_reg_read_valid_o = id_reg_read_valid_i;
    assign regfile_reg_read_addr_o  = id_reg_read_addr_i;

    // Acceptance walks oldest to youngest: a slot needs every older valid
    // slot accepted and no source that an older accepted slot writes.
    always_comb begin
        w_accepted = '0;
        w_hazard   = '0;
        w_prior_ok = '0;
        w_lower_ok = 1'b1;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            for (int j = 0; j < i; j++) begin
                for (int k = 0; k < 2; k++) begin
                    if (w_accepted[j] && id_reg_write_valid_i[j] &&
                        id_reg_read_valid_i[i*2+k] &&
                        (id_reg_read_addr_i[(i*2+k)*RA +: RA] != '0) &&
                        (id_reg_read_addr_i[(i*2+k)*RA +: RA] ==
                         id_reg_write_addr_i[j*RA +: RA])) begin
                        w_hazard[i] = 1'b1;
                    end
                end
            end
            w_prior_ok[i] = w_lower_ok;
            w_accepted[i] = rst_n & w_advance & ~flush_i & id_valid_i[i] &
                            w_lower_ok & ~w_hazard[i];
            w_lower_ok    = w_lower_ok & (~id_valid_i[i] | w_accepted[i]);
        end
    end

    assign w_split = w_advance & ~flush_i & |(id_valid_i & w_prior_ok & w_hazard);

    // Source operand select: r0 is hard zero, else lowest matching fwd port,
    // else the regfile read data.
    always_comb begin
        for (int n = 0; n < NSRC; n++) begin
            w_src[n] = regfile_reg_read_data_i[n*DW +: DW];
            for (int p = FWD_PORTS - 1; p >= 0; p--) begin
                if (fwd_valid_i[p] &&
                    (fwd_addr_i[p*RA +: RA] == id_reg_read_addr_i[n*RA +: RA])) begin
                    w_src[n] = fwd_data_i[p*DW +: DW];
                end
            end
            if (id_reg_read_addr_i[n*RA +: RA] == '0) begin
                w_src[n] = '0;
            end
        end
    end

    // Operand 2 mux and branch-compare flags (flags always use src2, not imm).
    always_comb begin
        w_op2   = '0;
        w_flags = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            w_op2[i*DW +: DW] = id_use_imm_i[i] ? id_imm_i[i*DW +: DW] : w_src[2*i+1];
            w_flags[i*6+0] = (w_src[2*i] == w_src[2*i+1]);
            w_flags[i*6+1] = (w_src[2*i] != w_src[2*i+1]);
            w_flags[i*6+2] = ($signed(w_src[2*i]) <  $signed(w_src[2*i+1]));
            w_flags[i*6+3] = ($signed(w_src[2*i]) >= $signed(w_src[2*i+1]));
            w_flags[i*6+4] = (w_src[2*i] <  w_src[2*i+1]);
            w_flags[i*6+5] = (w_src[2*i] >= w_src[2*i+1]);
        end
    end

    // Output register: flush drops the bundle, advance loads accepted slots,
    // otherwise everything holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exe_valid <= '0;
            r_oprand1   <= '0;
            r_oprand2   <= '0;
            r_imm       <= '0;
            r_flags     <= '0;
            r_wr_valid  <= '0;
            r_wr_addr   <= '0;
            r_payload   <= '0;
        end else if (flush_i) begin
            r_exe_valid <= '0;
        end else if (w_advance) begin
            r_exe_valid <= w_accepted;
            for (int i = 0; i < DECODE_WIDTH; i++) begin
                if (w_accepted[i]) begin
                    r_oprand1[i*DW +: DW] <= w_src[2*i];
                    r_oprand2[i*DW +: DW] <= w_op2[i*DW +: DW];
                    r_imm[i*DW +: DW]     <= id_imm_i[i*DW +: DW];
                    r_flags[i*6 +: 6]     <= w_flags[i*6 +: 6];
                    r_wr_valid[i]         <= id_reg_write_valid_i[i];
                    r_wr_addr[i*RA +: RA] <= id_reg_write_addr_i[i*RA +: RA];
                    r_payload[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] <=
                        id_payload_i[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
                end
            end
        end
    end

    assign exe_valid_o             = r_exe_valid;
    assign exe_oprand1_o           = r_oprand1;
    assign exe_oprand2_o           = r_oprand2;
    assign exe_imm_o               = r_imm;
    assign exe_branch_com_result_o = r_flags;
    assign exe_reg_write_valid_o   = r_wr_valid;
    assign exe_reg_write_addr_o    = r_wr_addr;
    assign exe_payload_o           = r_payload;

`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_split_cnt;

    // Saturating counters: stalled cycles with pending ID work, and
    // advance cycles that split a bundle on an intra-bundle hazard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_split_cnt <= '0;
        end else begin
            if ((|id_valid_i) && !w_advance && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_split && (r_split_cnt != '1)) begin
                r_split_cnt <= r_split_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o = r_stall_cnt;
    assign perf_split_cnt_o = r_split_cnt;
`else
    logic w_unused;
    assign w_unused = w_split;
`endif

endmodule

// File: doc/dispatch_hs.md
Name: dispatch_hs

Overview:
Parametrised successor to the pass-through dispatch stage; sits between ID and EXE. It registers a DECODE_WIDTH-wide bundle with a valid/ready handshake, and reads the regfile combinationally. It resolves RAW hazards by forwarding from later stages and by splitting bundles on intra-bundle dependencies. It also precomputes the six branch-compare flags from the forwarded operands.

Parameters:
DECODE_WIDTH, 2, instruction slots per bundle
DATA_WIDTH, 32, register/operand width
REG_ADDR_WIDTH, 5, architectural register index width
FWD_PORTS, 2, forwarding sources (port 0 = youngest, highest priority)
PAYLOAD_WIDTH, 64, opaque per-slot info passed to EXE (instr_info/aluop/alusel/csr fields)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  synchronous pipeline flush
id_valid_i  in  DECODE_WIDTH  slot valid from ID
id_accept_o  out  DECODE_WIDTH  slot consumed this cycle (combinational)
id_reg_read_valid_i  in  DECODE_WIDTH x 2  source-operand read enables {src2,src1}
id_reg_read_addr_i  in  DECODE_WIDTH x 2 x REG_ADDR_WIDTH  source addresses
id_use_imm_i  in  DECODE_WIDTH  oprand2 takes imm
id_imm_i  in  DECODE_WIDTH x DATA_WIDTH  immediate
id_reg_write_valid_i  in  DECODE_WIDTH  destination write enable
id_reg_write_addr_i  in  DECODE_WIDTH x REG_ADDR_WIDTH  destination
id_payload_i  in  DECODE_WIDTH x PAYLOAD_WIDTH  opaque payload
regfile_reg_read_valid_o  out  DECODE_WIDTH x 2  = id_reg_read_valid_i (combinational)
regfile_reg_read_addr_o  out  DECODE_WIDTH x 2 x REG_ADDR_WIDTH  = id_reg_read_addr_i (combinational)
regfile_reg_read_data_i  in  DECODE_WIDTH x 2 x DATA_WIDTH  same-cycle read data
fwd_valid_i  in  FWD_PORTS  forwarding write valid
fwd_addr_i  in  FWD_PORTS x REG_ADDR_WIDTH  forwarding destination
fwd_data_i  in  FWD_PORTS x DATA_WIDTH  forwarding data
exe_ready_i  in  1  EXE accepts the whole bundle
exe_valid_o  out  DECODE_WIDTH  registered slot valid
exe_oprand1_o, exe_oprand2_o, exe_imm_o  out  DECODE_WIDTH x DATA_WIDTH  registered operands
exe_branch_com_result_o  out  DECODE_WIDTH x 6  registered flags
exe_reg_write_valid_o / exe_reg_write_addr_o / exe_payload_o  out  per slot  registered copies

Behaviour:
- Reset (rst_n low, async): every exe_* output = 0; id_accept_o = 0 while in reset.
- advance = ~|exe_valid_o | exe_ready_i. EXE consumes all valid slots in a single handshake.
- Slot i is accepted when advance & id_valid_i[i] & ~flush_i, every lower slot j is invalid or accepted, and there is no intra-bundle hazard.
- Intra-bundle hazard: slot i reads a nonzero address that an accepted lower slot writes (read_valid & reg_write_valid & addr match).
- id_accept_o[i] = accepted[i]. ID holds unaccepted slots in place and re-presents them next cycle.
- Operand source x = forwarded value:
  - Address 0 always yields 0.
  - Otherwise use the lowest-index fwd port with valid and matching address.
  - Otherwise use regfile_reg_read_data_i.
- oprand1 = src1; oprand2 = use_imm ? imm : src2.
- Flags computed on src1/src2, never on imm: [0] eq, [1] ne, [2] signed lt, [3] signed ge, [4] unsigned lt, [5] unsigned ge.
- Register update on advance:
  - exe_valid_o[i] <= accepted[i].
  - Data fields load for accepted slots; non-accepted slots keep their old data, and only valid is cleared.
- Register hold when not advancing: all outputs held stable.
- Latency: 1 cycle from acceptance to exe_valid_o.
- flush_i: exe_valid_o <= 0 next edge regardless of exe_ready_i; no acceptance that cycle. Flush has priority over advance.
- Reset mid-bundle: pending bundle dropped, no partial state remains.

Optional Feature:
DISPATCH_PERF_CNT_EN: when defined, adds outputs perf_stall_cnt_o (32) and perf_split_cnt_o (32).
- perf_stall_cnt_o counts cycles with any id_valid_i and ~advance.
- perf_split_cnt_o counts advance cycles where a valid slot was refused due to an intra-bundle hazard.
- Both counters saturate at all-ones and reset to 0.
- When undefined: ports and counters are absent, and the rest of the behaviour is identical.

Test Plan:
- Two independent slots, r1=5, r2=7 in regfile, exe_ready_i=1: next cycle exe_valid_o=2'b11, slot0 oprand1=5, oprand2=7, flags eq=0, ne=1, lt=1, ult=1.
- Slot0 writes r3, slot1 reads r3: id_accept_o=2'b01. Next cycle slot1 re-presented alone → accepted, exe_valid_o=2'b10.
- fwd0 (r4=0xAA) and fwd1 (r4=0xBB) both valid, regfile r4=0x11: oprand1=0xAA. Read of r0 with fwd to r0=0x55 → 0.
- Signed compare src1=0xFFFFFFFF, src2=1: signed lt=1, ge=0; unsigned lt=0, ge=1.
- exe_ready_i=0 with exe_valid_o=2'b11: outputs stable and id_accept_o=0 for 3 cycles. Then flush_i=1 → exe_valid_o=0 next cycle.
- Assert rst_n low mid-stream: all exe outputs 0 immediately (async). Perf counters (if enabled) read 0.
